// File: rtl/spin_ctrl.sv
// rtl/spin_ctrl.sv - LED ring spinner: random target, constant-speed laps, deceleration, result hold
module spin_ctrl #(
  parameter int BASE_DIV    = 1_000_000,
  parameter int SLOW_INC    = 250_000,
  parameter int SPIN_ROUNDS = 3,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  rnd_i,
  output logic        rng_en_o,
  output logic [15:0] led_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  result_o
);
  localparam int MAX_PERIOD = BASE_DIV + 31 * SLOW_INC;
  localparam int PW         = $clog2(MAX_PERIOD + 1);
  localparam int SPIN_STEPS = 16 * SPIN_ROUNDS;
  localparam int SW_RAW     = $clog2(SPIN_STEPS + 1);
  localparam int SW         = (SW_RAW > 5) ? SW_RAW : 5;
  localparam int HW         = $clog2(SHOW_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_SLOW, S_SHOW} state_t;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_pos, w_pos_nx;
  logic [3:0]      r_target, w_target_nx;
  logic [PW-1:0]   r_period, w_period_nx;
  logic [PW-1:0]   r_cnt, w_cnt_nx;
  logic [SW-1:0]   r_steps, w_steps_nx;
  logic [SW-1:0]   r_slow_steps, w_slow_steps_nx;
  logic [HW-1:0]   r_show_cnt, w_show_cnt_nx;
  logic [3:0]      r_result, w_result_nx;
  logic            w_done_nx;
  logic            r_start_q, r_done, r_busy, r_rng_en;
  logic [15:0]     r_led;

  logic            w_start_edge;
  logic            w_step_end;
  logic [3:0]      w_pos_inc;
  logic [3:0]      w_diff;

  assign w_start_edge = start_i & ~r_start_q;
  assign w_step_end   = (r_cnt == r_period - PW'(1));
  assign w_pos_inc    = r_pos + 4'd1;
  // Distance to target is taken modulo 16 so the slow phase always has 16..31 steps
  assign w_diff       = r_target - w_pos_inc;

  always_comb begin
    w_state_nx      = r_state;
    w_pos_nx        = r_pos;
    w_target_nx     = r_target;
    w_period_nx     = r_period;
    w_cnt_nx        = r_cnt;
    w_steps_nx      = r_steps;
    w_slow_steps_nx = r_slow_steps;
    w_show_cnt_nx   = r_show_cnt;
    w_result_nx     = r_result;
    w_done_nx       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_target_nx = rnd_i;
          w_state_nx  = S_SPIN;
          w_period_nx = PW'(BASE_DIV);
          w_cnt_nx    = '0;
          w_steps_nx  = '0;
        end
      end
      S_SPIN, S_SLOW: begin
        if (w_step_end) begin
          w_cnt_nx   = '0;
          w_pos_nx   = w_pos_inc;
          w_steps_nx = r_steps + SW'(1);
          if (r_state == S_SPIN) begin
            if (r_steps + SW'(1) == SW'(SPIN_STEPS)) begin
              w_state_nx      = S_SLOW;
              w_period_nx     = PW'(BASE_DIV + SLOW_INC);
              w_steps_nx      = '0;
              w_slow_steps_nx = SW'(16) + SW'(w_diff);
            end
          end else if (r_steps + SW'(1) == r_slow_steps) begin
            w_state_nx    = S_SHOW;
            w_result_nx   = r_target;
            w_done_nx     = 1'b1;
            w_show_cnt_nx = '0;
          end else begin
            w_period_nx = r_period + PW'(SLOW_INC);
          end
        end else begin
          w_cnt_nx = r_cnt + PW'(1);
        end
      end
      S_SHOW: begin
        if (r_show_cnt == HW'(SHOW_CYCLES - 1)) begin
          w_state_nx = S_IDLE;
        end else begin
          w_show_cnt_nx = r_show_cnt + HW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_pos        <= 4'd0;
      r_target     <= 4'd0;
      r_period     <= '0;
      r_cnt        <= '0;
      r_steps      <= '0;
      r_slow_steps <= '0;
      r_show_cnt   <= '0;
      r_result     <= 4'd0;
      r_start_q    <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_rng_en     <= 1'b1;
      r_led        <= 16'h0001;
    end else begin
      r_state      <= w_state_nx;
      r_pos        <= w_pos_nx;
      r_target     <= w_target_nx;
      r_period     <= w_period_nx;
      r_cnt        <= w_cnt_nx;
      r_steps      <= w_steps_nx;
      r_slow_steps <= w_slow_steps_nx;
      r_show_cnt   <= w_show_cnt_nx;
      r_result     <= w_result_nx;
      r_start_q    <= start_i;
      r_done       <= w_done_nx;
      r_busy       <= (w_state_nx != S_IDLE);
      r_rng_en     <= (w_state_nx == S_IDLE);
      r_led        <= 16'h0001 << w_pos_nx;
    end
  end

  assign rng_en_o = r_rng_en;
  assign led_o    = r_led;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;
endmodule

// File: tb/tb_spin_ctrl.sv
// tb/tb_spin_ctrl.sv - self-checking bench for spin_ctrl
module tb_spin_ctrl;
  localparam int BD = 4;
  localparam int SI = 2;
  localparam int SR = 1;
  localparam int SC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  rnd_i = 4'd0;
  logic        rng_en_o;
  logic [15:0] led_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  result_o;

  always #5 clk = ~clk;

  spin_ctrl #(
    .BASE_DIV(BD), .SLOW_INC(SI), .SPIN_ROUNDS(SR), .SHOW_CYCLES(SC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .rnd_i(rnd_i),
    .rng_en_o(rng_en_o), .led_o(led_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] m_pos = 4'd0;
  logic [3:0] m_result = 4'd0;

  typedef struct {
    logic [3:0]  rnd;
    bit          noise;
    int          cycles;
    logic [3:0]  res;
    logic [15:0] led;
  } vec_t;

  function automatic logic [31:0] pack(logic [15:0] led, logic busy, logic done, logic rng, logic [3:0] res);
    return {9'd0, led, busy, done, rng, res};
  endfunction

  function automatic logic [31:0] act_vec();
    return pack(led_o, busy_o, done_o, rng_en_o, result_o);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: step durations from the rules, LED position = steps whose end time has passed
  task automatic run_spin(input logic [3:0] rnd, input bit noise, input bit hold,
                          output int k_done, output logic [15:0] led_at_done);
    int cum[64];
    int n_slow, n_steps, total, sd, dur;
    logic [3:0] p0, diff, exp_pos;
    bit busy;
    p0 = m_pos;
    diff = rnd - p0;
    n_slow = 16 + int'(diff);
    n_steps = 16 * SR + n_slow;
    total = 0;
    for (int j = 0; j < n_steps; j++) begin
      dur = (j < 16 * SR) ? BD : BD + (j - 16 * SR + 1) * SI;
      total += dur;
      cum[j] = total;
    end
    k_done = -1;
    led_at_done = 16'h0;
    @(negedge clk);
    start_i = 1'b1;
    rnd_i = rnd;
    for (int k = 0; k <= total + 10; k++) begin
      @(negedge clk);
      sd = 0;
      for (int j = 0; j < n_steps; j++) if (cum[j] <= k) sd++;
      exp_pos = p0 + 4'(sd);
      busy = (k < total + SC);
      check($sformatf("cyc k=%0d", k), act_vec(),
            pack(16'h0001 << exp_pos, busy, k == total, !busy, (k >= total) ? rnd : m_result));
      if (done_o && k_done < 0) begin
        k_done = k;
        led_at_done = led_o;
      end
      rnd_i = 4'($urandom);
      if (!hold) start_i = (noise && k < total) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    m_pos = rnd;
    m_result = rnd;
  endtask

  initial begin
    vec_t tbl[3];
    int kd;
    logic [15:0] ld;

    tbl[0] = '{4'd5, 1'b1, 610, 4'd5, 16'h0020};
    tbl[1] = '{4'd5, 1'b0, 400, 4'd5, 16'h0020};
    tbl[2] = '{4'd4, 1'b1, 1180, 4'd4, 16'h0010};

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_hold", act_vec(), pack(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0));
      start_i = ~start_i;
      rnd_i = 4'($urandom);
    end
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_idle", act_vec(), pack(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0));
    end

    for (int i = 0; i < 3; i++) begin
      run_spin(tbl[i].rnd, tbl[i].noise, 1'b0, kd, ld);
      check($sformatf("tbl%0d_cycles", i), 32'(kd), 32'(tbl[i].cycles));
      check($sformatf("tbl%0d_result", i), {28'd0, result_o}, {28'd0, tbl[i].res});
      check($sformatf("tbl%0d_led", i), {16'd0, ld}, {16'd0, tbl[i].led});
    end

    // Start held high across the return to IDLE must not retrigger
    run_spin(4'($urandom), 1'b0, 1'b1, kd, ld);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("held_start_idle", act_vec(), pack(16'h0001 << m_pos, 1'b0, 1'b0, 1'b1, m_result));
    end
    start_i = 1'b0;

    for (int n = 0; n < 8; n++) begin
      run_spin(4'($urandom), 1'b1, 1'b0, kd, ld);
    end

    // Asynchronous reset mid-SLOW
    @(negedge clk);
    start_i = 1'b1;
    rnd_i = 4'($urandom);
    @(negedge clk);
    start_i = 1'b0;
    repeat (16 * SR * BD + 20) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", act_vec(), pack(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("in_reset", act_vec(), pack(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0));
    end
    rst = 1'b1;
    m_pos = 4'd0;
    m_result = 4'd0;
    run_spin(4'($urandom), 1'b0, 1'b0, kd, ld);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
